// File: rtl/imm_narrower.sv
// Two-stage pipeline that narrows a datapath word to an IMM_W-bit immediate and
// flags whether the value survives the narrowing, with a saturating miss counter.
module imm_narrower #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned IMM_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_fits,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_data_q,  s1_data_d;
    logic             s1_signed_q, s1_signed_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IMM_W-1:0] s2_imm_q,   s2_imm_d;
    logic             s2_fits_q,  s2_fits_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic                  in_fire, out_fire, s2_load, fits;
    logic [IN_W-IMM_W-1:0] upper;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

    // Signed fit: the discarded bits must all replicate the new sign bit.
    assign upper = s1_data_q[IN_W-1:IMM_W];
    assign fits  = s1_signed_q ? (upper == {(IN_W-IMM_W){s1_data_q[IMM_W-1]}})
                               : (upper == '0);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_signed_d = s1_signed_q;
        s2_valid_d  = s2_valid_q;
        s2_imm_d    = s2_imm_q;
        s2_fits_d   = s2_fits_q;
        err_cnt_d   = err_cnt_q;

        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_data_d   = in_data;
            s1_signed_d = in_signed;
        end else if (s2_load) begin
            s1_valid_d  = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_imm_d   = s1_data_q[IMM_W-1:0];
            s2_fits_d  = fits;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        if (clear_cnt) begin
            err_cnt_d = '0;
        end else if (out_fire && !s2_fits_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_signed_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_imm_q    <= '0;
            s2_fits_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_signed_q <= s1_signed_d;
            s2_valid_q  <= s2_valid_d;
            s2_imm_q    <= s2_imm_d;
            s2_fits_q   <= s2_fits_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_imm   = s2_imm_q;
    assign out_fits  = s2_fits_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_narrower.sv
// Directed self-checking bench for imm_narrower with default parameters.
module tb_imm_narrower;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_imm;
    logic        out_fits;
    logic        clear_cnt;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    imm_narrower #(.IN_W(16), .IMM_W(4), .CNT_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fits  (out_fits),
        .clear_cnt (clear_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word for a single accepting edge, then wait for it to reach S2.
    task automatic push(input logic [15:0] d, input logic s);
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_data   = 16'hDEAD;
        tick();
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_imm !== 4'h0) begin n_err++; $display("FAIL rst_out_imm: got %h want 0", out_imm); end
        n_cmp++; if (out_fits !== 1'b0) begin n_err++; $display("FAIL rst_out_fits: got %b want 0", out_fits); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_signed_fit();
        out_ready = 1'b1;
        in_data = 16'hFFFA; in_signed = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_2: got %b want 1", out_valid); end
        n_cmp++; if (out_imm !== 4'b1010) begin n_err++; $display("FAIL fffa_s_imm: got %b want 1010", out_imm); end
        n_cmp++; if (out_fits !== 1'b1) begin n_err++; $display("FAIL fffa_s_fits: got %b want 1", out_fits); end
        tick();
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL fffa_s_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_1: got %b want 0", out_valid); end
    endtask

    task automatic test_modes();
        out_ready = 1'b1;
        push(16'h0006, 1'b1);
        n_cmp++; if (out_imm !== 4'b0110 || out_fits !== 1'b1) begin n_err++; $display("FAIL 0006_s: got %b/%b want 0110/1", out_imm, out_fits); end
        push(16'hFFFA, 1'b0);
        n_cmp++; if (out_imm !== 4'b1010 || out_fits !== 1'b0) begin n_err++; $display("FAIL fffa_u: got %b/%b want 1010/0", out_imm, out_fits); end
        tick();
        n_cmp++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL fffa_u_cnt: got %0d want 1", err_cnt); end
        push(16'h0010, 1'b1);
        n_cmp++; if (out_imm !== 4'b0000 || out_fits !== 1'b0) begin n_err++; $display("FAIL 0010_s: got %b/%b want 0000/0", out_imm, out_fits); end
        push(16'hFFF7, 1'b1);
        n_cmp++; if (out_imm !== 4'b0111 || out_fits !== 1'b0) begin n_err++; $display("FAIL fff7_s: got %b/%b want 0111/0", out_imm, out_fits); end
        tick();
        n_cmp++; if (err_cnt !== 8'd3) begin n_err++; $display("FAIL cnt_plus2: got %0d want 3", err_cnt); end
        // Boundary values at the edge of each range.
        push(16'hFFF8, 1'b1);
        n_cmp++; if (out_imm !== 4'b1000 || out_fits !== 1'b1) begin n_err++; $display("FAIL fff8_s: got %b/%b want 1000/1", out_imm, out_fits); end
        push(16'h0008, 1'b1);
        n_cmp++; if (out_fits !== 1'b0) begin n_err++; $display("FAIL 0008_s: got %b want 0", out_fits); end
        push(16'h000F, 1'b0);
        n_cmp++; if (out_imm !== 4'hF || out_fits !== 1'b1) begin n_err++; $display("FAIL 000f_u: got %h/%b want f/1", out_imm, out_fits); end
        tick();
        n_cmp++; if (err_cnt !== 8'd4) begin n_err++; $display("FAIL cnt_boundary: got %0d want 4", err_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy_a: got %b want 1", in_ready); end
        tick();
        in_data = 16'h0002;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy_b: got %b want 1", in_ready); end
        tick();
        in_data = 16'h0003;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy_c: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy_hold: got %b want 0", in_ready); end
        in_data = 16'h0005;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 4'h1) begin n_err++; $display("FAIL bp_hold: got %b/%h want 1/1", out_valid, out_imm); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 4'h2) begin n_err++; $display("FAIL bp_second: got %b/%h want 1/2", out_valid, out_imm); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_only2: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [5] = '{16'h0003, 16'hFFFC, 16'h0007, 16'hFFF9, 16'h0000};
        out_ready = 1'b1;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = w[k];
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy%0d: got %b want 1", k, in_ready); end
            tick();
            if (k >= 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_imm !== w[k-1][3:0]) begin
                    n_err++; $display("FAIL b2b_out%0d: got %b/%h want 1/%h", k - 1, out_valid, out_imm, w[k-1][3:0]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 4'h0) begin n_err++; $display("FAIL b2b_last: got %b/%h want 1/0", out_valid, out_imm); end
        tick();
        n_cmp++; if (err_cnt !== 8'd4) begin n_err++; $display("FAIL b2b_cnt: got %0d want 4", err_cnt); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        in_signed = 1'b0;
        in_data   = 16'h0010;
        in_valid  = 1'b1;
        for (int k = 0; k < 260; k++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL sat: got %0d want 255", err_cnt); end
        out_ready = 1'b0;
        push(16'h0010, 1'b0);
        clear_cnt = 1'b1;
        out_ready = 1'b1;
        tick();
        clear_cnt = 1'b0;
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL clr_prio: got %0d want 0", err_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_xfer: got %b want 0", out_valid); end
        push(16'h0020, 1'b0);
        tick();
        n_cmp++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL post_clr: got %0d want 1", err_cnt); end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0001; tick();
        in_data   = 16'h0002; tick();
        in_valid  = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_rdy: got %b want 0", in_ready); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_rdy: got %b want 1", in_ready); end
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = 16'h0005; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_1: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 4'h5) begin n_err++; $display("FAIL post_rst_2: got %b/%h want 1/5", out_valid, out_imm); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_3: got %b want 0", out_valid); end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        clear_cnt = 1'b0;
        #12;
        test_reset();
        reset_n = 1'b1;
        tick();
        test_signed_fit();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_narrower.md
IMM_NARROWER -- requirements
Module: imm_narrower

Interface
REQ-001 The block SHALL have parameter IN_W, default 16: width of the datapath word.
REQ-002 The block SHALL have parameter IMM_W, default 4: width of the narrowed immediate field; IMM_W < IN_W.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-004 The block SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1: in_data/in_signed are valid.
REQ-007 The block SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-008 The block SHALL have port in_data, input, IN_W: full-width value to narrow.
REQ-009 The block SHALL have port in_signed, input, 1: 1 = signed range check, 0 = unsigned.
REQ-010 The block SHALL have port out_valid, output, 1: out_imm/out_fits are valid.
REQ-011 The block SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 The block SHALL have port out_imm, output, IMM_W: narrowed field.
REQ-013 The block SHALL have port out_fits, output, 1: value is exactly representable in IMM_W bits.
REQ-014 The block SHALL have port clear_cnt, input, 1: synchronous clear of err_cnt.
REQ-015 The block SHALL have port err_cnt, output, CNT_W: saturating count of non-fitting results delivered.

Function
REQ-016 The block SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-017 The block SHALL be a 2-stage pipeline: S1 registers in_data/in_signed; S2 registers out_imm/out_fits/out_valid.
REQ-018 The block SHALL present out_valid on the 2nd rising edge after input acceptance when unstalled.
REQ-019 The block SHALL set out_imm = in_data[IMM_W-1:0] regardless of fit.
REQ-020 The block SHALL set out_fits = 1 in signed mode iff in_data[IN_W-1:IMM_W] are all equal to in_data[IMM_W-1], i.e. the inverse of sign extension.
REQ-021 The block SHALL set out_fits = 1 in unsigned mode iff in_data[IN_W-1:IMM_W] == 0.
REQ-022 The block SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; S1 SHALL advance into S2 whenever S2 is empty or being drained.
REQ-023 The block SHALL hold out_valid, out_imm and out_fits stable while out_valid && !out_ready.
REQ-024 The block SHALL preserve order; no word is dropped or duplicated; with out_ready low, at most 2 words are held.
REQ-025 The block SHALL accept an input and emit an output in the same cycle when both stages are full and out_ready=1, sustaining 1 word/cycle.
REQ-026 The block SHALL increment err_cnt by 1 on each output transfer with out_fits=0.
REQ-027 The block SHALL saturate err_cnt at 2^CNT_W-1.
REQ-028 clear_cnt=1 SHALL force err_cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-029 The block SHALL ignore in_data and in_signed when no input transfer occurs.

Reset
REQ-030 While reset_n=0, the block SHALL asynchronously clear s1_valid, out_valid, out_imm, out_fits and err_cnt to 0.
REQ-031 While reset_n=0, in_ready SHALL be 1 (both stages empty).
REQ-032 Assertion of reset_n mid-operation SHALL discard in-flight words; after release the first accepted word SHALL appear 2 cycles later.

Verification
REQ-033 The bench SHALL cover: signed, in_data=0xFFFA -> 2 cycles later out_imm=4'b1010, out_fits=1, err_cnt=0.
REQ-034 The bench SHALL cover: signed 0x0006 -> out_imm=4'b0110, out_fits=1; unsigned 0xFFFA -> out_imm=4'b1010, out_fits=0, err_cnt=1.
REQ-035 The bench SHALL cover: signed 0x0010 -> out_imm=4'b0000, out_fits=0; signed 0xFFF7 -> out_fits=0; err_cnt +2.
REQ-036 The bench SHALL cover: out_ready=0 with 3 back-to-back inputs -> exactly 2 accepted, in_ready=0; after out_ready=1, results appear in order, 1 per cycle.
REQ-037 The bench SHALL cover: 260 non-fitting transfers -> err_cnt=255; clear_cnt asserted with a simultaneous non-fitting transfer -> err_cnt=0.
REQ-038 The bench SHALL cover: reset_n pulsed low with both stages full -> out_valid=0, err_cnt=0 immediately; in_ready=1.
